// File: rtl/mem_slave_wait.sv
// Word-addressed memory slave with wait-state insertion and a one-cycle active-low ACK_N.
// Define MEM_WAIT_PROG_EN to take the wait count from the WAIT_CFG port instead of WAIT_STATES.
module mem_slave_wait #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
`ifdef MEM_WAIT_PROG_EN
  input  logic [3:0]        WAIT_CFG,
`endif
  output logic [DATA_W-1:0] DOUT,
  output logic              ACK_N
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RECOVER} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ack_n_q, ack_n_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [3:0]          wait_ld;
  logic                commit;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_din;
  logic                acc_wr;

`ifdef MEM_WAIT_PROG_EN
  assign wait_ld = WAIT_CFG;
`else
  assign wait_ld = 4'(WAIT_STATES);
`endif

  // A zero-wait access commits on the acceptance edge itself, so the access
  // operands come straight from the inputs in IDLE and from the latches otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    dout_d   = dout_q;
    ack_n_d  = 1'b1;
    commit   = 1'b0;
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_wr   = wr_q;
    case (state_q)
      S_IDLE: begin
        if (MR || MW) begin
          addr_d   = ADDR;
          din_d    = DIN;
          wr_d     = MW;
          cnt_d    = wait_ld;
          acc_addr = ADDR;
          acc_din  = DIN;
          acc_wr   = MW;
          if (wait_ld == 4'd0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (commit) begin
      ack_n_d = 1'b0;
      if (!acc_wr) begin
        dout_d = mem_q[acc_addr];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_n_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_n_q <= ack_n_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    din_q  <= din_d;
    wr_q   <= wr_d;
  end

  // Reset on the commit edge discards the write.
  always_ff @(posedge CLK) begin
    if (!RESET && commit && acc_wr) begin
      mem_q[acc_addr] <= acc_din;
    end
  end

  assign DOUT  = dout_q;
  assign ACK_N = ack_n_q;

endmodule

// File: tb/tb_mem_slave_wait.sv
// Directed bench for mem_slave_wait: one instance at two wait states, one at zero wait states.
module tb_mem_slave_wait;

  localparam int W2 = 2;

  logic        clk;
  logic        rst;
  logic        mr2, mw2, mr0, mw0;
  logic [7:0]  addr2, addr0;
  logic [31:0] din2, din0;
  logic [31:0] dout2, dout0;
  logic        ack2, ack0;
`ifdef MEM_WAIT_PROG_EN
  logic [3:0]  cfg2, cfg0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  mem_slave_wait #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) u_w2 (
    .CLK(clk), .RESET(rst), .MR(mr2), .MW(mw2), .ADDR(addr2), .DIN(din2),
`ifdef MEM_WAIT_PROG_EN
    .WAIT_CFG(cfg2),
`endif
    .DOUT(dout2), .ACK_N(ack2)
  );

  mem_slave_wait #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) u_w0 (
    .CLK(clk), .RESET(rst), .MR(mr0), .MW(mw0), .ADDR(addr0), .DIN(din0),
`ifdef MEM_WAIT_PROG_EN
    .WAIT_CFG(cfg0),
`endif
    .DOUT(dout0), .ACK_N(ack0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the W=2 instance; k counts negedges after the acceptance edge.
  task automatic acc2(input string tag, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [31:0] d, input bit drop,
                      input bit rel_rst, input logic [31:0] exp_dout);
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    mr2 = rd; mw2 = wr; addr2 = a; din2 = d;
    @(posedge clk);
    for (int k = 1; k <= W2 + 3; k++) begin
      @(negedge clk);
      if (k == 1 && drop) begin
        mr2 = 1'b0; mw2 = 1'b0; addr2 = a + 8'd1; din2 = ~d;
      end
      check_val({tag, "_ack"}, {31'd0, ack2}, (k == W2 + 1) ? 32'd0 : 32'd1);
      if (k == W2 + 1) begin
        check_val({tag, "_dout"}, dout2, exp_dout);
        mr2 = 1'b0; mw2 = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mr2 = 1'b0; mw2 = 1'b0; addr2 = 8'h00; din2 = 32'h0;
    mr0 = 1'b0; mw0 = 1'b0; addr0 = 8'h00; din0 = 32'h0;
`ifdef MEM_WAIT_PROG_EN
    cfg2 = 4'd2; cfg0 = 4'd0;
`endif
    repeat (2) @(posedge clk);

    // Reset held two edges with a request pending (MR+MW => write)
    @(negedge clk);
    rst = 1'b1; mr2 = 1'b1; mw2 = 1'b1; addr2 = 8'h10; din2 = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_ack2", {31'd0, ack2}, 32'd1);
    check_val("rst_dout2", dout2, 32'd0);
    check_val("rst_ack0", {31'd0, ack0}, 32'd1);
    check_val("rst_dout0", dout0, 32'd0);
    @(posedge clk);
    acc2("rst_accept", 1'b1, 1'b1, 8'h10, 32'h0BADF00D, 1'b0, 1'b1, 32'd0);

    acc2("wr05",  1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    acc2("rd05",  1'b1, 1'b0, 8'h05, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF);
    acc2("wr06",  1'b0, 1'b1, 8'h06, 32'h66666666, 1'b0, 1'b0, 32'hDEADBEEF);
    acc2("drop",  1'b0, 1'b1, 8'h05, 32'hCAFEF00D, 1'b1, 1'b0, 32'hDEADBEEF);
    acc2("rd05b", 1'b1, 1'b0, 8'h05, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D);
    acc2("rd06",  1'b1, 1'b0, 8'h06, 32'h0,        1'b0, 1'b0, 32'h66666666);
    acc2("both",  1'b1, 1'b1, 8'h07, 32'h77777777, 1'b0, 1'b0, 32'h66666666);
    acc2("rd07",  1'b1, 1'b0, 8'h07, 32'h0,        1'b0, 1'b0, 32'h77777777);

    // Reset while the write to 0x10 is in WAIT
    @(negedge clk);
    mw2 = 1'b1; addr2 = 8'h10; din2 = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    mw2 = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_dout", dout2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check_val("midrst_ack", {31'd0, ack2}, 32'd1);
      @(negedge clk);
    end
    acc2("rd10", 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 32'h0BADF00D);

    // Zero-wait instance: one write, then MR held for back-to-back reads
    @(negedge clk);
    mw0 = 1'b1; addr0 = 8'h01; din0 = 32'hA5A5A5A5;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_val("w0_wr_ack", {31'd0, ack0}, (k == 1) ? 32'd0 : 32'd1);
      if (k == 1) mw0 = 1'b0;
    end
    mr0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_val("w0_hold_ack", {31'd0, ack0}, (k % 3 == 1) ? 32'd0 : 32'd1);
      if (k % 3 == 1) check_val("w0_hold_dout", dout0, 32'hA5A5A5A5);
      if (k == 9) mr0 = 1'b0;
    end

`ifdef MEM_WAIT_PROG_EN
    // Runtime wait count sampled only at acceptance
    @(negedge clk);
    cfg2 = 4'd5; mr2 = 1'b1; addr2 = 8'h05;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) mr2 = 1'b0;
      if (k == 2) cfg2 = 4'd1;
      check_val("prog_ack", {31'd0, ack2}, (k == 6) ? 32'd0 : 32'd1);
      if (k == 6) check_val("prog_dout", dout2, 32'hCAFEF00D);
    end
    cfg2 = 4'd2;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
